// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage
package fetch_pkg;
  localparam int INSTR_WIDTH = 32;
  typedef enum logic [1:0] {
    NONE       = 2'b00,
    MISALIGNED = 2'b01,
    BUS_ERR    = 2'b10,
    PC_FAULT   = 2'b11
  } fetch_fault_e;
  typedef enum logic [1:0] {IDLE, BUS, RESP} fetch_state_e;
endpackage

// File: rtl/instruction_fetch.sv
// instruction_fetch: reads one 32-bit instruction at pc over a narrow req/ack bus and presents it with its pc and fault cause
// Ports: clk/reset; fetch_valid/fetch_ready/pc/pc_fault from the PC stage;
// mem_req/mem_addr/mem_ack/mem_rdata/mem_err to memory; flush discards the fetch;
// instr_valid/instr_ready/instr/instr_pc/fault_cause to the decoder.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_valid,
  output logic                  fetch_ready,
  input  logic [31:0]           pc,
  input  logic                  pc_fault,
  output logic                  mem_req,
  output logic [31:0]           mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_err,
  input  logic                  flush,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           instr,
  output logic [31:0]           instr_pc,
  output logic [1:0]            fault_cause
);
  localparam int BEATS = INSTR_WIDTH / DATA_WIDTH;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  fetch_state_e state_q, state_d;
  fetch_fault_e cause_q, cause_d;
  logic [BW-1:0] beat_q, beat_d;
  logic drop_q, drop_d;
  logic [31:0] pc_q, pc_d, instr_q, instr_d;
  logic last;
  assign last = beat_q == BW'(BEATS - 1);
  assign fetch_ready = state_q == IDLE;
  assign mem_req = state_q == BUS;
  assign mem_addr = mem_req ? pc_q + 32'(beat_q) * 32'(DATA_WIDTH / 8) : '0;
  // A flush in RESP discards the instruction, so it must not look consumable that cycle
  assign instr_valid = state_q == RESP && !flush;
  assign instr = instr_q;
  assign instr_pc = pc_q;
  assign fault_cause = cause_q;
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    beat_d  = beat_q;
    drop_d  = drop_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      IDLE: if (fetch_valid) begin
        pc_d    = pc;
        instr_d = '0;
        beat_d  = '0;
        drop_d  = 1'b0;
        cause_d = pc_fault ? PC_FAULT : (pc[1:0] != 2'b00 ? MISALIGNED : NONE);
        state_d = (pc_fault || pc[1:0] != 2'b00) ? RESP : BUS;
      end
      BUS: begin
        // An outstanding beat is always completed; a flush only marks the fetch for dropping
        drop_d = drop_q | flush;
        if (mem_ack) begin
          if (drop_d) begin
            drop_d  = 1'b0;
            state_d = IDLE;
          end else if (mem_err) begin
            cause_d = BUS_ERR;
            instr_d = '0;
            state_d = RESP;
          end else begin
            instr_d[beat_q*DATA_WIDTH +: DATA_WIDTH] = mem_rdata;
            state_d = last ? RESP : BUS;
            beat_d  = last ? beat_q : beat_q + BW'(1);
          end
        end
      end
      RESP: if (flush || instr_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cause_q <= NONE;
      beat_q  <= '0;
      drop_q  <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      beat_q  <= beat_d;
      drop_q  <= drop_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench for instruction_fetch at DATA_WIDTH 8 and 16
module tb_instruction_fetch;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic        fetch_valid = 1'b0, pc_fault = 1'b0, mem_ack = 1'b0, mem_err = 1'b0;
  logic        flush = 1'b0, instr_ready = 1'b1;
  logic [31:0] pc = '0;
  logic [7:0]  mem_rdata = '0;
  logic        fetch_ready, mem_req, instr_valid;
  logic [31:0] mem_addr, instr, instr_pc;
  logic [1:0]  fault_cause;
  logic        b_fv = 1'b0, b_pf = 1'b0, b_ack = 1'b0, b_err = 1'b0, b_flush = 1'b0, b_ready = 1'b1;
  logic [31:0] b_pc = '0;
  logic [15:0] b_rdata = '0;
  logic        b_fready, b_req, b_valid;
  logic [31:0] b_addr, b_instr, b_ipc;
  logic [1:0]  b_cause;

  instruction_fetch #(.DATA_WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
    .pc(pc), .pc_fault(pc_fault), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err), .flush(flush),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .fault_cause(fault_cause));

  instruction_fetch #(.DATA_WIDTH(16)) u16 (
    .clk(clk), .reset(reset), .fetch_valid(b_fv), .fetch_ready(b_fready),
    .pc(b_pc), .pc_fault(b_pf), .mem_req(b_req), .mem_addr(b_addr),
    .mem_ack(b_ack), .mem_rdata(b_rdata), .mem_err(b_err), .flush(b_flush),
    .instr_valid(b_valid), .instr_ready(b_ready), .instr(b_instr),
    .instr_pc(b_ipc), .fault_cause(b_cause));

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [1:0]  cause;
  } exp_t;
  exp_t sb[$];
  int vectors = 0, miscompares = 0;
  int delay = 0, cnt = 0, hs = 0, req_cycles = 0, ncyc = 0, b_hs = 0, b_err_beat = -1;
  bit valid_seen = 1'b0;
  logic [31:0] ack_addr[$];
  int ack_cyc[$];

  function automatic logic [7:0] mb(input logic [31:0] a);
    case (a)
      32'h100: return 8'h13;
      32'h101: return 8'h05;
      32'h102: return 8'h10;
      32'h103: return 8'h00;
      default: return a[7:0] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] word(input logic [31:0] a);
    return {mb(a + 3), mb(a + 2), mb(a + 1), mb(a)};
  endfunction

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] p, input logic [31:0] i, input logic [1:0] c);
    exp_t e;
    e.pc = p;
    e.instr = i;
    e.cause = c;
    sb.push_back(e);
  endtask

  // 8-bit memory responder with per-beat ack delay, plus output scoreboard
  initial forever begin
    @(negedge clk);
    ncyc++;
    if (reset || !mem_req) begin
      mem_ack = 1'b0;
      cnt = 0;
    end else begin
      req_cycles++;
      if (cnt == delay) begin
        mem_ack = 1'b1;
        mem_rdata = mb(mem_addr);
        hs++;
        ack_addr.push_back(mem_addr);
        ack_cyc.push_back(ncyc);
        cnt = 0;
      end else begin
        mem_ack = 1'b0;
        cnt++;
      end
    end
    if (instr_valid) valid_seen = 1'b1;
    if (!reset && instr_valid && instr_ready) begin
      expect_eq("sb_has_entry", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        expect_eq("instr", instr, e.instr);
        expect_eq("instr_pc", instr_pc, e.pc);
        expect_eq("fault_cause", 32'(fault_cause), 32'(e.cause));
      end
    end
  end

  // 16-bit memory responder, ack always high, error on a chosen handshake
  initial forever begin
    @(negedge clk);
    if (reset || !b_req) begin
      b_ack = 1'b0;
      b_err = 1'b0;
    end else begin
      b_ack = 1'b1;
      b_rdata = {mb(b_addr + 1), mb(b_addr)};
      b_err = b_hs == b_err_beat;
      b_hs++;
    end
  end

  task automatic accept(input logic [31:0] a, input logic f);
    @(posedge clk); #1;
    pc = a;
    pc_fault = f;
    fetch_valid = 1'b1;
    @(negedge clk);
    expect_eq("fetch_ready", 32'(fetch_ready), 32'd1);
    @(posedge clk); #1;
    fetch_valid = 1'b0;
    pc_fault = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!instr_valid && n < 40);
  endtask

  task automatic b_fetch(input logic [31:0] a, output int n);
    @(posedge clk); #1;
    b_pc = a;
    b_fv = 1'b1;
    @(posedge clk); #1;
    b_fv = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!b_valid && n < 40);
  endtask

  initial begin
    int n, k;
    #2;
    expect_eq("rst_mem_req", 32'(mem_req), 0);
    expect_eq("rst_instr_valid", 32'(instr_valid), 0);
    expect_eq("rst_instr", instr, 0);
    expect_eq("rst_instr_pc", instr_pc, 0);
    expect_eq("rst_cause", 32'(fault_cause), 0);
    expect_eq("rst_mem_addr", mem_addr, 0);
    expect_eq("rst_fetch_ready", 32'(fetch_ready), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    // aligned fetch, ack tied high
    ack_addr.delete();
    ack_cyc.delete();
    accept(32'h100, 1'b0);
    push(32'h100, 32'h00100513, 2'b00);
    wait_valid(n);
    expect_eq("lat_ok", n, 5);
    expect_eq("beats", ack_addr.size(), 4);
    for (int i = 0; i < 4 && i < ack_addr.size(); i++) begin
      expect_eq("beat_addr", ack_addr[i], 32'h100 + 32'(i));
      expect_eq("beat_cycle", ack_cyc[i], ack_cyc[0] + i);
    end
    // misaligned
    req_cycles = 0;
    accept(32'h102, 1'b0);
    push(32'h102, 32'h0, 2'b01);
    wait_valid(n);
    expect_eq("lat_misal", n, 1);
    repeat (3) @(posedge clk);
    expect_eq("misal_no_req", req_cycles, 0);
    // pc fault wins over misaligned
    accept(32'h102, 1'b1);
    push(32'h102, 32'h0, 2'b11);
    wait_valid(n);
    expect_eq("lat_pcf", n, 1);
    repeat (3) @(posedge clk);
    expect_eq("pcf_no_req", req_cycles, 0);
    // consumer stall: outputs hold in RESP
    instr_ready = 1'b0;
    accept(32'h300, 1'b0);
    push(32'h300, word(32'h300), 2'b00);
    wait_valid(n);
    expect_eq("lat_stall", n, 5);
    repeat (4) begin
      @(posedge clk); #1;
      expect_eq("stall_valid", 32'(instr_valid), 1);
      expect_eq("stall_instr", instr, word(32'h300));
      expect_eq("stall_pc", instr_pc, 32'h300);
      expect_eq("stall_cause", 32'(fault_cause), 0);
    end
    instr_ready = 1'b1;
    repeat (2) @(posedge clk);
    // flush during beat 1 with slow acks
    delay = 3;
    hs = 0;
    valid_seen = 1'b0;
    accept(32'h200, 1'b0);
    k = 0;
    while (hs < 1 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    expect_eq("beat0_done", hs, 1);
    flush = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      flush = 1'b0;
      expect_eq("hold_req", 32'(mem_req), 1);
      expect_eq("hold_addr", mem_addr, 32'h201);
    end
    repeat (8) @(posedge clk);
    #1;
    expect_eq("flush_beats", hs, 2);
    expect_eq("flush_no_valid", 32'(valid_seen), 0);
    expect_eq("flush_ready", 32'(fetch_ready), 1);
    expect_eq("flush_req_low", 32'(mem_req), 0);
    // flush in RESP discards even with instr_ready
    delay = 0;
    instr_ready = 1'b0;
    accept(32'h600, 1'b0);
    wait_valid(n);
    expect_eq("lat_resp_flush", n, 5);
    @(posedge clk); #1;
    flush = 1'b1;
    instr_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    expect_eq("rflush_ready", 32'(fetch_ready), 1);
    expect_eq("rflush_valid", 32'(instr_valid), 0);
    // asynchronous reset mid-BUS
    delay = 3;
    accept(32'h400, 1'b0);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    expect_eq("mid_rst_req", 32'(mem_req), 0);
    expect_eq("mid_rst_valid", 32'(instr_valid), 0);
    expect_eq("mid_rst_instr", instr, 0);
    expect_eq("mid_rst_pc", instr_pc, 0);
    expect_eq("mid_rst_cause", 32'(fault_cause), 0);
    expect_eq("mid_rst_addr", mem_addr, 0);
    expect_eq("mid_rst_ready", 32'(fetch_ready), 1);
    @(posedge clk); #1;
    reset = 1'b0;
    delay = 0;
    // 16-bit bus: normal fetch then bus error on beat 1
    b_hs = 0;
    b_err_beat = -1;
    b_fetch(32'h104, n);
    expect_eq("b_lat", n, 3);
    expect_eq("b_instr", b_instr, word(32'h104));
    expect_eq("b_cause_ok", 32'(b_cause), 0);
    expect_eq("b_beats_ok", b_hs, 2);
    @(posedge clk);
    b_hs = 0;
    b_err_beat = 1;
    b_fetch(32'h500, n);
    expect_eq("b_err_lat", n, 3);
    expect_eq("b_err_cause", 32'(b_cause), 2);
    expect_eq("b_err_instr", b_instr, 0);
    expect_eq("b_err_pc", b_ipc, 32'h500);
    repeat (4) @(posedge clk);
    expect_eq("b_err_reqs", b_hs, 2);
    expect_eq("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout vectors=%0d", vectors);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Sits directly downstream of the program counter and upstream of the decoder.
- Accepts the current PC and its fault flag, then reads one 32-bit instruction over a narrow req/ack memory bus in DATA_WIDTH-bit beats.
- Assembles the beats little-endian and presents the instruction, with its PC and any fault cause, on a valid/ready handshake.

Parameters:
- DATA_WIDTH, 8: memory read bus width in bits. Legal values are 8, 16 and 32. BEATS = 32/DATA_WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- fetch_valid  in  1  request to fetch at pc
- fetch_ready  out  1  high in IDLE only
- pc  in  32  fetch address from the program counter
- pc_fault  in  1  program counter fault flag, sampled with pc
- mem_req  out  1  memory read request, held until acknowledged
- mem_addr  out  32  byte address of the current beat
- mem_ack  in  1  beat complete; mem_rdata and mem_err valid this cycle
- mem_rdata  in  DATA_WIDTH  read data
- mem_err  in  1  bus error, qualified by mem_ack
- flush  in  1  discard the in-flight or held fetch
- instr_valid  out  1  instruction/fault available
- instr_ready  in  1  consumer accepts
- instr  out  32  assembled instruction; 0 when fault_cause != 0
- instr_pc  out  32  PC of the presented instruction
- fault_cause  out  2  00 none, 01 misaligned, 10 bus error, 11 upstream pc fault

Behaviour:
- Reset (asynchronous, takes effect immediately): state IDLE; beat counter 0; drop flag 0.
  - Outputs during and after reset: mem_req 0, instr_valid 0, instr 0, instr_pc 0, fault_cause 00, mem_addr 0, fault_cause register 00.
  - fetch_ready is 1, since the state is IDLE.
- States: IDLE, BUS, RESP.
- IDLE:
  - On fetch_valid & fetch_ready, register pc into pc_q and clear the instruction register.
  - Fault check at acceptance; priority pc_fault > misaligned:
    - pc_fault = 1 -> cause 11, go to RESP.
    - else pc[1:0] != 0 -> cause 01, go to RESP.
    - else -> go to BUS with beat = 0.
  - No memory access occurs on either fault path.
- BUS:
  - mem_req = 1 combinationally from state. mem_addr = pc_q + beat*(DATA_WIDTH/8), 32-bit wrap-around.
  - mem_req stays high, with address stable, until mem_ack.
  - On mem_ack & !mem_err: write mem_rdata into instr bits [beat*DATA_WIDTH +: DATA_WIDTH].
    - If beat == BEATS-1, go to RESP; otherwise increment beat.
  - On mem_ack & mem_err: cause 10, instr 0, abort remaining beats, go to RESP.
- RESP:
  - instr_valid = 1. instr, instr_pc = pc_q and fault_cause stay stable until instr_ready.
  - On instr_valid & instr_ready, go to IDLE in the next cycle.
- Latency with mem_ack tied high:
  - Accept at cycle N, beats at N+1..N+BEATS, instr_valid at N+BEATS+1.
  - Fault at acceptance: instr_valid at N+1.
  - Throughput is one fetch per BEATS+2 cycles.
- flush:
  - IDLE: no effect; a fetch_valid in the same cycle is still accepted.
  - BUS: a beat handshake is never abandoned. Set the drop flag and finish the current beat (wait for mem_ack). Then go to IDLE with no instr_valid and issue no further beats.
  - RESP: go to IDLE next cycle; the instruction is discarded even if instr_ready is high the same cycle.
- A fault_cause of 01, 11 or 10 carries no instruction. The consumer raises the exception.
- mem_err without mem_ack is ignored. mem_ack outside BUS is ignored.

Decomposition:
- Shared package fetch_pkg holds:
  - fetch_fault_e (NONE, MISALIGNED, BUS_ERR, PC_FAULT)
  - fetch_state_e (IDLE, BUS, RESP)
  - the INSTR_WIDTH = 32 constant
- No sub-module. Beat assembly is a small indexed write inside this module.

Test Plan:
- DATA_WIDTH=8, pc=0x100, mem_ack tied high, rdata = 0x13,0x05,0x10,0x00:
  - mem_addr 0x100..0x103 on consecutive cycles.
  - instr=0x00100513, instr_pc=0x100, cause 00, instr_valid at accept+5.
- pc=0x102, pc_fault=0 -> mem_req never asserts; instr_valid at accept+1, cause 01, instr 0.
- pc_fault=1 with pc=0x102 -> cause 11 (priority over misaligned), no memory access.
- DATA_WIDTH=16, beat 1 returns mem_ack with mem_err=1 -> cause 10, instr 0, exactly 2 requests issued.
- mem_ack delayed 3 cycles per beat, flush pulsed during beat 1:
  - mem_req and mem_addr are held until ack.
  - No beat 2 is issued, instr_valid never rises, fetch_ready returns.
- instr_ready held low 4 cycles in RESP -> outputs stable. reset asserted mid-BUS -> mem_req drops immediately, all outputs 0, fetch_ready 1.
